// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - jump-game score keeper: BCD score, centre combo, play/game-over lights
module score_keeper #(
    parameter int BLINK_HALF = 25000000,
    parameter int COMBO_MAX  = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        land_vld,
    input  logic        land_hit,
    input  logic        land_center,
    output logic [15:0] digits,
    output logic [2:0]  combo,
    output logic        light_on,
    output logic        light_blink
);

    localparam int          CW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [2:0]  CMAX = 3'(COMBO_MAX);
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t          state_q, state_d;
    logic [15:0]     digits_q, digits_d;
    logic [2:0]      combo_q, combo_d;
    logic [CW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            blink_q, blink_d;

    logic            landing;
    logic [2:0]      combo_inc;
    logic [3:0]      points;
    logic [15:0]     digits_sum;
    logic            sum_ovf;

    // start always wins over a coincident landing
    assign landing   = (state_q == PLAY) && land_vld && !start;
    assign combo_inc = (combo_q >= CMAX) ? CMAX : combo_q + 3'd1;
    assign points    = land_center ? {combo_inc, 1'b0} : 4'd1;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= IDLE;
            digits_q    <= 16'h0000;
            combo_q     <= 3'd0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            digits_q    <= digits_d;
            combo_q     <= combo_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = PLAY;
            PLAY:    if (!start && land_vld && !land_hit) state_d = OVER;
            OVER:    if (start) state_d = PLAY;
            default: state_d = IDLE;
        endcase
    end

    // Decimal ripple add of a small point value; carry out of the top digit saturates.
    always_comb begin
        logic [4:0] acc;
        logic [1:0] carry;
        digits_sum = 16'h0000;
        carry      = 2'd0;
        acc        = 5'd0;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) acc = {1'b0, digits_q[3:0]} + {1'b0, points};
            else        acc = {1'b0, digits_q[4*i +: 4]} + {3'b000, carry};
            if (acc >= 5'd20) begin
                acc   = acc - 5'd20;
                carry = 2'd2;
            end else if (acc >= 5'd10) begin
                acc   = acc - 5'd10;
                carry = 2'd1;
            end else begin
                carry = 2'd0;
            end
            digits_sum[4*i +: 4] = acc[3:0];
        end
        sum_ovf = (carry != 2'd0);
    end

    always_comb begin
        digits_d = digits_q;
        combo_d  = combo_q;
        if (start) begin
            digits_d = 16'h0000;
            combo_d  = 3'd0;
        end else if (landing) begin
            combo_d = 3'd0;
            if (land_hit) begin
                digits_d = sum_ovf ? 16'h9999 : digits_sum;
                if (land_center) combo_d = combo_inc;
            end
        end
    end

    always_comb begin
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if (state_q == OVER && state_d == OVER) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                blink_d     = blink_q;
            end
        end
    end

    always_comb begin
        light_on    = (state_q == PLAY);
        light_blink = blink_q;
        digits      = digits_q;
        combo       = combo_q;
    end

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - randomized and directed checks of score_keeper against a behavioural model
module tb_score_keeper;

    localparam int BH   = 4;
    localparam int CMAX = 4;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0, land_vld = 1'b0, land_hit = 1'b0, land_center = 1'b0;
    logic [15:0] digits;
    logic [2:0]  combo;
    logic        light_on, light_blink;

    int checks = 0;
    int errors = 0;

    score_keeper #(.BLINK_HALF(BH), .COMBO_MAX(CMAX)) dut (
        .clk(clk), .clr(clr), .start(start), .land_vld(land_vld),
        .land_hit(land_hit), .land_center(land_center),
        .digits(digits), .combo(combo), .light_on(light_on), .light_blink(light_blink)
    );

    always #5 clk = ~clk;

    // Model: 0 idle, 1 playing, 2 game over; score as a plain integer.
    int m_st = 0, m_score = 0, m_combo = 0, m_over = 0;

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_st = 0; m_score = 0; m_combo = 0; m_over = 0;
        end else if (start) begin
            m_st = 1; m_score = 0; m_combo = 0;
        end else if (m_st == 1 && land_vld) begin
            if (!land_hit) begin
                m_st = 2; m_combo = 0; m_over = 0;
            end else if (!land_center) begin
                m_combo = 0;
                m_score = (m_score + 1 > 9999) ? 9999 : m_score + 1;
            end else begin
                m_combo = (m_combo + 1 > CMAX) ? CMAX : m_combo + 1;
                m_score = (m_score + 2 * m_combo > 9999) ? 9999 : m_score + 2 * m_combo;
            end
        end else if (m_st == 2) begin
            m_over = m_over + 1;
        end
    end

    function automatic logic [15:0] to_bcd(input int s);
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    bit run_cmp = 1'b1;
    always @(negedge clk) begin
        if (run_cmp) begin
            chk("digits", 32'(digits), 32'(to_bcd(m_score)));
            chk("combo", 32'(combo), 32'(m_combo));
            chk("light_on", 32'(light_on), 32'(m_st == 1));
            chk("light_blink", 32'(light_blink), 32'(m_st == 2 && ((m_over / BH) % 2) == 1));
        end
    end

    task automatic tick(input logic s, input logic v, input logic h, input logic c);
        @(negedge clk);
        start = s; land_vld = v; land_hit = h; land_center = c;
        @(posedge clk);
        #1;
        start = 0; land_vld = 0; land_hit = 0; land_center = 0;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 clr = 1'b0;
        #1;
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_combo", 32'(combo), 32'h0);
        chk("rst_light_on", 32'(light_on), 32'h0);
        chk("rst_blink", 32'(light_blink), 32'h0);
        @(negedge clk);
        clr = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_digits", 32'(digits), 32'h0);
        chk("reset_light_on", 32'(light_on), 32'h0);
        clr = 1'b1;
        // release cycle: landing in IDLE is ignored
        tick(0, 1, 1, 0);
        chk("idle_ignore", 32'(digits), 32'h0);

        tick(1, 0, 0, 0);
        repeat (3) tick(0, 1, 1, 0);
        chk("three_plain", 32'(digits), 32'h0003);
        chk("three_plain_on", 32'(light_on), 32'h1);

        tick(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 1, 1, 1);
            chk("centre_combo", 32'(combo), (i < 4) ? 32'(i + 1) : 32'd4);
        end
        chk("centre_sum", 32'(digits), 32'h0028);

        tick(1, 0, 0, 0);
        repeat (98) tick(0, 1, 1, 0);
        chk("preload_98", 32'(digits), 32'h0098);
        tick(0, 1, 1, 1);
        chk("carry_0100", 32'(digits), 32'h0100);

        // start coincident with a landing in PLAY: start wins
        tick(1, 1, 1, 1);
        chk("start_wins", 32'(digits), 32'h0);

        while (9983 - m_score > 8) tick(0, 1, 1, 1);
        while (m_score < 9983) tick(0, 1, 1, 0);
        repeat (3) tick(0, 1, 1, 1);
        chk("pre_9995", 32'(digits), 32'h9995);
        chk("pre_combo3", 32'(combo), 32'h3);
        tick(0, 1, 1, 1);
        chk("sat_9999", 32'(digits), 32'h9999);
        chk("sat_combo4", 32'(combo), 32'h4);
        tick(0, 1, 1, 1);
        chk("sat_hold", 32'(digits), 32'h9999);

        tick(1, 0, 0, 0);
        tick(0, 1, 1, 0);
        tick(0, 1, 0, 1);
        chk("over_light_on", 32'(light_on), 32'h0);
        chk("over_combo", 32'(combo), 32'h0);
        repeat (BH - 1) tick(0, 1, 1, 1);
        chk("blink_before", 32'(light_blink), 32'h0);
        tick(0, 1, 1, 0);
        chk("blink_first", 32'(light_blink), 32'h1);
        chk("over_frozen", 32'(digits), 32'h0001);
        repeat (BH) tick(0, 0, 0, 0);
        chk("blink_second", 32'(light_blink), 32'h0);

        tick(1, 1, 1, 0);
        chk("restart_digits", 32'(digits), 32'h0);
        chk("restart_on", 32'(light_on), 32'h1);
        tick(0, 1, 1, 1);
        async_reset();
        tick(0, 1, 1, 0);
        chk("post_rst_idle", 32'(light_on), 32'h0);

        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r == 0) begin
                async_reset();
            end else begin
                logic s;
                s = (m_st == 1) ? ($urandom_range(0, 99) < 2) : ($urandom_range(0, 99) < 15);
                tick(s, $urandom_range(0, 1) == 1, $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1);
            end
        end

        @(negedge clk);
        run_cmp = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 The block SHALL have parameter BLINK_HALF, default 25000000, the number of clk cycles per half-period of light_blink (0.5 s at 50 MHz).
REQ-002 The block SHALL have parameter COMBO_MAX, default 4, the saturation value of the centre-landing combo counter.
REQ-003 The block SHALL have port clk, input, 1 bit, the 50 MHz master clock; all state changes on its rising edge.
REQ-004 The block SHALL have port clr, input, 1 bit, reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit, a one-cycle pulse that begins a new game.
REQ-006 The block SHALL have port land_vld, input, 1 bit, a one-cycle pulse from fsm marking the end of a jump.
REQ-007 The block SHALL have port land_hit, input, 1 bit, qualified by land_vld: 1 means the player landed on a square, 0 means a miss.
REQ-008 The block SHALL have port land_center, input, 1 bit, qualified by land_vld and land_hit: 1 means a centre landing.
REQ-009 The block SHALL have port digits, output, 16 bits, the 4-digit packed BCD score for segdisplay, with [15:12] as the thousands digit.
REQ-010 The block SHALL have port combo, output, 3 bits, the current combo count.
REQ-011 The block SHALL have port light_on, output, 1 bit, high while the game is in progress.
REQ-012 The block SHALL have port light_blink, output, 1 bit, a square wave while in game-over.

Function
REQ-013 The block SHALL have exactly three states: IDLE, PLAY and OVER.
REQ-014 IDLE SHALL go to PLAY on start; PLAY SHALL go to OVER on land_vld with land_hit=0; OVER SHALL go to PLAY on start.
REQ-015 On every start pulse (from IDLE or OVER), digits SHALL be cleared to 0x0000 and combo to 0 in the same edge as the state change.
REQ-016 start asserted while in PLAY SHALL clear digits and combo, and the state SHALL remain PLAY.
REQ-017 land_vld SHALL be ignored in IDLE and OVER.
REQ-018 In PLAY, land_vld with land_hit=1 and land_center=0 SHALL add 1 point and set combo to 0.
REQ-019 In PLAY, land_vld with land_hit=1 and land_center=1 SHALL set combo to min(combo+1, COMBO_MAX) and then add 2*(new combo) points (2, 4, 6, 8, 8, ...).
REQ-020 In PLAY, land_vld with land_hit=0 SHALL leave digits unchanged, set combo to 0 and enter OVER.
REQ-021 The score update SHALL use decimal BCD addition with carry rippling across all four digits, and every digit nibble SHALL always hold a value in 0..9.
REQ-022 The score SHALL saturate at 0x9999 and never wrap to 0x0000.
REQ-023 digits and combo SHALL reflect a landing one clk cycle after the land_vld edge (a registered update, latency 1).
REQ-024 land_vld and start asserted in the same cycle SHALL be resolved in favour of start, and the landing SHALL be discarded.
REQ-025 land_center SHALL be ignored when land_hit=0.
REQ-026 light_on SHALL be 1 exactly when the state is PLAY.
REQ-027 In OVER, a counter SHALL run from 0 to BLINK_HALF-1 and toggle light_blink on wrap, with the first toggle BLINK_HALF cycles after entry.
REQ-028 Outside OVER, light_blink SHALL be 0 and the blink counter SHALL be held at 0.
REQ-029 The blink counter SHALL be ceil(log2(BLINK_HALF)) bits wide and SHALL restart from 0 on each entry to OVER.

Reset
REQ-030 clr=0 SHALL asynchronously force: state IDLE, digits 0x0000, combo 0, light_on 0, light_blink 0, blink counter 0.
REQ-031 Reset asserted mid-game or mid-blink SHALL abandon the game, and after release the block SHALL wait in IDLE for start.
REQ-032 Release of clr SHALL take effect on the next rising clk edge, and no landing SHALL be scored in the release cycle unless the state is already PLAY.

Verification
REQ-033 Scenario: reset, start, then 3 plain hits -> digits=0x0003, combo=0, light_on=1.
REQ-034 Scenario: start, then 5 centre hits -> combo sequence 1,2,3,4,4, digits=0x0028 (2+4+6+8+8).
REQ-035 Scenario: preload to 0x0098 via plain hits, then one centre hit (combo 0->1) -> digits=0x0100 (BCD carry across two digits).
REQ-036 Scenario: reach 0x9995 with combo at 3, then centre hit -> digits=0x9999 (saturated), combo=4.
REQ-037 Scenario: start, then a miss, with BLINK_HALF=4 -> OVER, light_on=0, light_blink toggles every 4 cycles, digits frozen; further land_vld has no effect.
REQ-038 Scenario: start coincident with land_vld hit in OVER, then clr=0 mid-PLAY -> digits=0x0000, state PLAY; then asynchronous return to IDLE with all outputs 0.
